// File: rtl/spi_byte_target.sv
// spi_byte_target: SPI mode-0 target front end. Synchronizes the raw SPI pins
// into the clk domain, detects SCK edges and shifts MSB-first bytes in and
// out, presenting a byte-wide receive strobe and a transmit-load strobe.
module spi_byte_target #(
  parameter logic CS_ACTIVE = 1'b0,
  parameter logic IDLE_CIPO = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_sck_i,
  input  logic       spi_copi_i,
  input  logic       spi_cs_i,
  output logic       spi_cipo_o,
  output logic [7:0] rx_byte_o,
  output logic       rx_valid_o,
  input  logic [7:0] tx_byte_i,
  output logic       tx_load_o,
  output logic       selected_o,
  output logic       dbg_receive,
  output logic       dbg_transmit,
  output logic       dbg_sck_rise,
  output logic       dbg_sck_fall
);

  typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

  state_t     r_state;
  state_t     w_state_n;

  logic       r_sck_s1, r_sck_s2, r_sck_s3;
  logic       r_copi_s1, r_copi_s2;
  logic       r_cs_s1, r_cs_s2;
  logic [1:0] r_flush;
  logic       r_armed;

  logic [2:0] r_bit_cnt;
  logic [7:0] r_rx_sh;
  logic [7:0] r_tx_sh;
  logic [7:0] r_rx_byte;
  logic       r_rx_pend;
  logic       r_rx_valid;
  logic       r_cipo;
  logic       r_dbg_rise;
  logic       r_dbg_fall;

  logic       w_cs_act;
  logic       w_rise;
  logic       w_fall;
  logic       w_tx_load;
  logic       w_clr_cnt;
  logic       w_shift_rx;
  logic       w_shift_tx;
  logic [7:0] w_tx_sh_n;

  assign w_cs_act = (r_cs_s2 == CS_ACTIVE);
  assign w_rise   = r_sck_s2 & ~r_sck_s3;
  assign w_fall   = ~r_sck_s2 & r_sck_s3;

  // Pin synchronizers plus the re-arm logic: after reset the synchronizer
  // pipeline must flush before a CS level can be trusted, and the block only
  // arms once it has actually seen CS inactive, so a CS held through reset
  // is not mistaken for a fresh assert.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sck_s1  <= 1'b0;
      r_sck_s2  <= 1'b0;
      r_sck_s3  <= 1'b0;
      r_copi_s1 <= 1'b0;
      r_copi_s2 <= 1'b0;
      r_cs_s1   <= ~CS_ACTIVE;
      r_cs_s2   <= ~CS_ACTIVE;
      r_flush   <= 2'b00;
      r_armed   <= 1'b0;
    end else begin
      r_sck_s1  <= spi_sck_i;
      r_sck_s2  <= r_sck_s1;
      r_sck_s3  <= r_sck_s2;
      r_copi_s1 <= spi_copi_i;
      r_copi_s2 <= r_copi_s1;
      r_cs_s1   <= spi_cs_i;
      r_cs_s2   <= r_cs_s1;
      r_flush   <= {r_flush[0], 1'b1};
      if (r_flush[1] && !w_cs_act) begin
        r_armed <= 1'b1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_n;
    end
  end

  // FSM next state and per-cycle control strobes; CS deassert beats any edge.
  always_comb begin
    w_state_n  = r_state;
    w_tx_load  = 1'b0;
    w_clr_cnt  = 1'b0;
    w_shift_rx = 1'b0;
    w_shift_tx = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_cs_act && r_armed) begin
          w_state_n = ST_ACTIVE;
          w_clr_cnt = 1'b1;
          w_tx_load = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (!w_cs_act) begin
          w_state_n = ST_IDLE;
          w_clr_cnt = 1'b1;
        end else if (w_rise) begin
          w_shift_rx = 1'b1;
        end else if (w_fall) begin
          if (r_bit_cnt == 3'd0) begin
            w_tx_load = 1'b1;
          end else begin
            w_shift_tx = 1'b1;
          end
        end
      end
      default: w_state_n = ST_IDLE;
    endcase
    if (reset) begin
      w_tx_load = 1'b0;
    end
  end

  // Next transmit shifter contents, shared by the shifter and the CIPO flop.
  always_comb begin
    w_tx_sh_n = r_tx_sh;
    if (w_tx_load) begin
      w_tx_sh_n = tx_byte_i;
    end else if (w_shift_tx) begin
      w_tx_sh_n = {r_tx_sh[6:0], 1'b0};
    end
  end

  // Bit counter, receive/transmit shifters, byte strobe and registered CIPO.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bit_cnt  <= 3'd0;
      r_rx_sh    <= 8'h00;
      r_tx_sh    <= 8'h00;
      r_rx_byte  <= 8'h00;
      r_rx_pend  <= 1'b0;
      r_rx_valid <= 1'b0;
      r_cipo     <= IDLE_CIPO;
      r_dbg_rise <= 1'b0;
      r_dbg_fall <= 1'b0;
    end else begin
      r_rx_valid <= r_rx_pend;
      r_rx_pend  <= 1'b0;
      r_dbg_rise <= w_rise;
      r_dbg_fall <= w_fall;
      r_tx_sh    <= w_tx_sh_n;
      r_cipo     <= (w_state_n == ST_ACTIVE) ? w_tx_sh_n[7] : IDLE_CIPO;
      if (w_clr_cnt) begin
        r_bit_cnt <= 3'd0;
      end else if (w_shift_rx) begin
        r_bit_cnt <= r_bit_cnt + 3'd1;
        r_rx_sh   <= {r_rx_sh[6:0], r_copi_s2};
        if (r_bit_cnt == 3'd7) begin
          r_rx_byte <= {r_rx_sh[6:0], r_copi_s2};
          r_rx_pend <= 1'b1;
        end
      end
    end
  end

  assign spi_cipo_o   = r_cipo;
  assign rx_byte_o    = r_rx_byte;
  assign rx_valid_o   = r_rx_valid;
  assign tx_load_o    = w_tx_load;
  assign selected_o   = w_cs_act;
  assign dbg_receive  = r_rx_valid;
  assign dbg_transmit = w_tx_load;
  assign dbg_sck_rise = r_dbg_rise;
  assign dbg_sck_fall = r_dbg_fall;

endmodule

// File: tb/tb_spi_byte_target.sv
// Testbench for spi_byte_target: a host model drives the SPI pins on the
// falling clk edge, a monitor counts the DUT strobes and logs received bytes.
module tb_spi_byte_target;

  logic       clk = 1'b0;
  logic       reset;
  logic       spi_sck_i;
  logic       spi_copi_i;
  logic       spi_cs_i;
  logic       spi_cipo_o;
  logic [7:0] rx_byte_o;
  logic       rx_valid_o;
  logic [7:0] tx_byte_i;
  logic       tx_load_o;
  logic       selected_o;
  logic       dbg_receive;
  logic       dbg_transmit;
  logic       dbg_sck_rise;
  logic       dbg_sck_fall;

  always #5 clk = ~clk;

  spi_byte_target dut (
    .clk          (clk),
    .reset        (reset),
    .spi_sck_i    (spi_sck_i),
    .spi_copi_i   (spi_copi_i),
    .spi_cs_i     (spi_cs_i),
    .spi_cipo_o   (spi_cipo_o),
    .rx_byte_o    (rx_byte_o),
    .rx_valid_o   (rx_valid_o),
    .tx_byte_i    (tx_byte_i),
    .tx_load_o    (tx_load_o),
    .selected_o   (selected_o),
    .dbg_receive  (dbg_receive),
    .dbg_transmit (dbg_transmit),
    .dbg_sck_rise (dbg_sck_rise),
    .dbg_sck_fall (dbg_sck_fall)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  int rx_cnt   = 0;
  int txl_cnt  = 0;
  int rise_cnt = 0;
  int fall_cnt = 0;
  int dr_cnt   = 0;
  int dt_cnt   = 0;
  logic [7:0] rx_log[$];

  int b_rx, b_tl, b_r, b_f, b_dr, b_dt;

  // Strobe monitor, sampling mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (rx_valid_o === 1'b1) begin
        rx_cnt++;
        rx_log.push_back(rx_byte_o);
      end
      if (tx_load_o === 1'b1)    txl_cnt++;
      if (dbg_sck_rise === 1'b1) rise_cnt++;
      if (dbg_sck_fall === 1'b1) fall_cnt++;
      if (dbg_receive === 1'b1)  dr_cnt++;
      if (dbg_transmit === 1'b1) dt_cnt++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic snap();
    b_rx = rx_cnt; b_tl = txl_cnt; b_r = rise_cnt;
    b_f  = fall_cnt; b_dr = dr_cnt; b_dt = dt_cnt;
  endtask

  function automatic logic [7:0] rx_at(input int idx);
    if (idx < rx_log.size()) return rx_log[idx];
    return 8'hxx;
  endfunction

  // Host shifts nbits MSB-first; CIPO is captured at the end of each SCK high phase.
  task automatic host_bits(input logic [7:0] mosi, input int nbits, input int half,
                           output logic [7:0] got);
    logic [7:0] sh;
    sh  = mosi;
    got = 8'h00;
    for (int k = 0; k < nbits; k++) begin
      spi_copi_i = sh[7];
      sh = {sh[6:0], 1'b0};
      tick(half);
      spi_sck_i = 1'b1;
      tick(half);
      got = {got[6:0], spi_cipo_o};
      spi_sck_i = 1'b0;
    end
  endtask

  task automatic cs_on();
    spi_cs_i = 1'b0;
    tick(4);
  endtask

  task automatic cs_off();
    tick(4);
    spi_cs_i = 1'b1;
    tick(5);
  endtask

  typedef struct {
    int         half;
    logic [7:0] mosi;
    logic [7:0] txb;
    logic [7:0] exp_rx;
    logic [7:0] exp_host;
  } vec_t;

  vec_t       vecs[4];
  vec_t       v;
  logic [7:0] got;
  logic [7:0] g0, g1, g2, g3;

  initial begin
    vecs[0] = '{half: 4, mosi: 8'hA5, txb: 8'h3C, exp_rx: 8'hA5, exp_host: 8'h3C};
    vecs[1] = '{half: 2, mosi: 8'h96, txb: 8'h69, exp_rx: 8'h96, exp_host: 8'h69};
    vecs[2] = '{half: 3, mosi: 8'h00, txb: 8'hFF, exp_rx: 8'h00, exp_host: 8'hFF};
    vecs[3] = '{half: 4, mosi: 8'hFF, txb: 8'h00, exp_rx: 8'hFF, exp_host: 8'h00};

    reset      = 1'b1;
    spi_sck_i  = 1'b0;
    spi_copi_i = 1'b0;
    spi_cs_i   = 1'b1;
    tx_byte_i  = 8'h00;
    tick(3);
    check("rst_cipo",     32'(spi_cipo_o),   32'h1);
    check("rst_rx_byte",  32'(rx_byte_o),    32'h0);
    check("rst_rx_valid", 32'(rx_valid_o),   32'h0);
    check("rst_tx_load",  32'(tx_load_o),    32'h0);
    check("rst_selected", 32'(selected_o),   32'h0);
    check("rst_dbg",      32'({dbg_receive, dbg_transmit, dbg_sck_rise, dbg_sck_fall}), 32'h0);
    reset = 1'b0;
    tick(6);

    // Single-byte transactions; the last SCK fall of a byte opens the next
    // byte, so tx_load_o pulses at CS assert and again after bit 0.
    for (int i = 0; i < 4; i++) begin
      v = vecs[i];
      tx_byte_i = v.txb;
      tick(2);
      snap();
      cs_on();
      check($sformatf("v%0d_load_at_cs", i), 32'(txl_cnt - b_tl), 32'd1);
      check($sformatf("v%0d_selected", i),   32'(selected_o),     32'h1);
      host_bits(v.mosi, 8, v.half, got);
      cs_off();
      check($sformatf("v%0d_rx_count", i),   32'(rx_cnt - b_rx),  32'd1);
      check($sformatf("v%0d_rx_byte", i),    32'(rx_at(b_rx)),    32'(v.exp_rx));
      check($sformatf("v%0d_host_byte", i),  32'(got),            32'(v.exp_host));
      check($sformatf("v%0d_tx_loads", i),   32'(txl_cnt - b_tl), 32'd2);
      check($sformatf("v%0d_sck_rises", i),  32'(rise_cnt - b_r), 32'd8);
      check($sformatf("v%0d_sck_falls", i),  32'(fall_cnt - b_f), 32'd8);
      check($sformatf("v%0d_dbg_recv", i),   32'(dr_cnt - b_dr),  32'd1);
      check($sformatf("v%0d_dbg_xmit", i),   32'(dt_cnt - b_dt),  32'd2);
      check($sformatf("v%0d_idle_cipo", i),  32'(spi_cipo_o),     32'h1);
      check($sformatf("v%0d_deselected", i), 32'(selected_o),     32'h0);
    end

    // Back-to-back bytes, refreshing tx_byte_i after every load.
    tx_byte_i = 8'hE7;
    tick(2);
    snap();
    cs_on();
    tx_byte_i = 8'h11;
    host_bits(8'h01, 8, 4, g0);
    tick(4);
    tx_byte_i = 8'h22;
    host_bits(8'h80, 8, 4, g1);
    tick(4);
    tx_byte_i = 8'h33;
    host_bits(8'hFF, 8, 4, g2);
    tick(4);
    host_bits(8'h00, 8, 4, g3);
    cs_off();
    check("b2b_rx_count", 32'(rx_cnt - b_rx),  32'd4);
    check("b2b_rx0",      32'(rx_at(b_rx)),     32'h01);
    check("b2b_rx1",      32'(rx_at(b_rx + 1)), 32'h80);
    check("b2b_rx2",      32'(rx_at(b_rx + 2)), 32'hFF);
    check("b2b_rx3",      32'(rx_at(b_rx + 3)), 32'h00);
    check("b2b_host0",    32'(g0), 32'hE7);
    check("b2b_host1",    32'(g1), 32'h11);
    check("b2b_host2",    32'(g2), 32'h22);
    check("b2b_host3",    32'(g3), 32'h33);
    check("b2b_tx_loads", 32'(txl_cnt - b_tl), 32'd5);

    // Partial byte discarded on CS deassert, then a clean byte.
    tx_byte_i = 8'hA5;
    tick(2);
    snap();
    cs_on();
    host_bits(8'h5A, 5, 4, got);
    cs_off();
    check("part_rx_count", 32'(rx_cnt - b_rx), 32'd0);
    check("part_cipo",     32'(spi_cipo_o),    32'h1);
    tx_byte_i = 8'h3C;
    snap();
    cs_on();
    host_bits(8'h5A, 8, 4, got);
    cs_off();
    check("after_part_rx_count", 32'(rx_cnt - b_rx), 32'd1);
    check("after_part_rx_byte",  32'(rx_at(b_rx)),    32'h5A);
    check("after_part_host",     32'(got),            32'h3C);

    // Reset during bit 3 with CS held asserted.
    tx_byte_i = 8'h77;
    cs_on();
    host_bits(8'hC3, 3, 4, got);
    spi_copi_i = 1'b0;
    tick(4);
    spi_sck_i = 1'b1;
    tick(2);
    reset = 1'b1;
    tick(1);
    check("midrst_cipo",     32'(spi_cipo_o), 32'h1);
    check("midrst_rx_byte",  32'(rx_byte_o),  32'h0);
    check("midrst_rx_valid", 32'(rx_valid_o), 32'h0);
    check("midrst_tx_load",  32'(tx_load_o),  32'h0);
    check("midrst_selected", 32'(selected_o), 32'h0);
    check("midrst_dbg",      32'({dbg_receive, dbg_transmit, dbg_sck_rise, dbg_sck_fall}), 32'h0);
    spi_sck_i = 1'b0;
    tick(1);
    reset = 1'b0;
    tick(6);
    check("postrst_selected", 32'(selected_o), 32'h1);
    snap();
    host_bits(8'hC3, 8, 4, got);
    tick(4);
    check("postrst_no_rx",   32'(rx_cnt - b_rx),  32'd0);
    check("postrst_no_load", 32'(txl_cnt - b_tl), 32'd0);
    check("postrst_cipo",    32'(got),            32'hFF);
    spi_cs_i = 1'b1;
    tick(5);
    tx_byte_i = 8'h5E;
    snap();
    cs_on();
    host_bits(8'hC3, 8, 4, got);
    cs_off();
    check("rearm_rx_count", 32'(rx_cnt - b_rx), 32'd1);
    check("rearm_rx_byte",  32'(rx_at(b_rx)),    32'hC3);
    check("rearm_host",     32'(got),            32'h5E);

    // 4x-limit SCK with CS deassert landing on the 8th rise detect.
    tx_byte_i = 8'h69;
    tick(2);
    snap();
    cs_on();
    host_bits(8'h96, 7, 2, got);
    spi_copi_i = 1'b0;
    tick(2);
    spi_sck_i = 1'b1;
    spi_cs_i  = 1'b1;
    tick(2);
    spi_sck_i = 1'b0;
    tick(6);
    check("coinc_no_rx",  32'(rx_cnt - b_rx),  32'd0);
    check("coinc_rises",  32'(rise_cnt - b_r), 32'd8);
    check("coinc_falls",  32'(fall_cnt - b_f), 32'd8);
    check("coinc_host7",  32'(got),            32'h34);
    check("coinc_cipo",   32'(spi_cipo_o),     32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
